// File: rtl/udp_rx_packer_if.sv
// rtl/udp_rx_packer_if.sv - UDP payload byte stream in, packed packet with valid/ready out
interface udp_rx_packer_if #(
    parameter int MAX_BYTES = 1024,
    parameter int CNT_W     = 16
);
    logic                   udp_rec_data_valid;
    logic [7:0]             udp_rec_rdata;
    logic [15:0]            udp_rec_data_length;
    logic                   udp_rx_data_valid;
    logic                   udp_rx_data_ready;
    logic [MAX_BYTES*8-1:0] udp_rx_data;
    logic [CNT_W-1:0]       udp_rx_data_length;
    logic                   udp_rx_overflow;
    logic                   udp_rx_len_err;
    logic [15:0]            udp_rx_drop_cnt;

    modport master (
        output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, udp_rx_data_ready,
        input  udp_rx_data_valid, udp_rx_data, udp_rx_data_length,
        input  udp_rx_overflow, udp_rx_len_err, udp_rx_drop_cnt
    );

    modport slave (
        input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, udp_rx_data_ready,
        output udp_rx_data_valid, udp_rx_data, udp_rx_data_length,
        output udp_rx_overflow, udp_rx_len_err, udp_rx_drop_cnt
    );
endinterface

// File: rtl/udp_rx_packer.sv
// rtl/udp_rx_packer.sv - packs a UDP payload byte stream into one wide word; optional UDP_RX_LEN_CHECK_EN
module udp_rx_packer #(
    parameter int MAX_BYTES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic           rgmii_clk,
    input  logic           rst,
    udp_rx_packer_if.slave bus
);
    localparam int               DW      = MAX_BYTES * 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rec_valid_d;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [DW-1:0]    data;
    logic             rx_valid;
    logic [CNT_W-1:0] rx_len;
    logic             rx_ovf;
    logic [15:0]      drop_cnt;
    logic             load_first;
    logic             take_byte;
    logic             enter_hold;
    logic             release_pkt;
    logic             drop_pkt;

    assign start    = bus.udp_rec_data_valid & ~rec_valid_d;
    assign drop_pkt = (state == HOLD) && start;

    always_ff @(posedge rgmii_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_first  = 1'b0;
        take_byte   = 1'b0;
        enter_hold  = 1'b0;
        release_pkt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_first = 1'b1;
                    state_nxt  = RECV;
                end
            end
            RECV: begin
                if (bus.udp_rec_data_valid) begin
                    take_byte = 1'b1;
                end else begin
                    enter_hold = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (bus.udp_rx_data_ready) begin
                    release_pkt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rec_valid_d resets high so a packet already streaming at reset release never forms a start
    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            rec_valid_d <= 1'b1;
            cnt         <= '0;
            ovf         <= 1'b0;
            data        <= '0;
            rx_valid    <= 1'b0;
            rx_len      <= '0;
            rx_ovf      <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            rec_valid_d <= bus.udp_rec_data_valid;
            if (load_first) begin
                data <= {{(DW-8){1'b0}}, bus.udp_rec_rdata};
                cnt  <= CNT_W'(1);
                ovf  <= 1'b0;
            end else if (take_byte) begin
                if (cnt < MAX_CNT) begin
                    data <= {data[DW-9:0], bus.udp_rec_rdata};
                    cnt  <= cnt + CNT_W'(1);
                end else begin
                    ovf <= 1'b1;
                end
            end
            if (enter_hold) begin
                rx_valid <= 1'b1;
                rx_len   <= cnt;
                rx_ovf   <= ovf;
            end else if (release_pkt) begin
                rx_valid <= 1'b0;
                rx_ovf   <= 1'b0;
            end
            if (drop_pkt) drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef UDP_RX_LEN_CHECK_EN
    logic [15:0] raw_cnt;
    logic [15:0] len_field;
    logic        len_err;

    // raw_cnt keeps counting past MAX_BYTES so truncation alone is not a length error
    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            raw_cnt   <= '0;
            len_field <= '0;
            len_err   <= 1'b0;
        end else begin
            if (load_first) begin
                raw_cnt   <= 16'd1;
                len_field <= bus.udp_rec_data_length;
            end else if (take_byte) begin
                raw_cnt <= raw_cnt + 16'd1;
            end
            if (enter_hold)       len_err <= (len_field < 16'd8) || (raw_cnt != (len_field - 16'd8));
            else if (release_pkt) len_err <= 1'b0;
        end
    end

    assign bus.udp_rx_len_err = len_err;
`else
    logic unused_len;
    assign unused_len         = ^bus.udp_rec_data_length;
    assign bus.udp_rx_len_err = 1'b0;
`endif

    assign bus.udp_rx_data_valid  = rx_valid;
    assign bus.udp_rx_data        = data;
    assign bus.udp_rx_data_length = rx_len;
    assign bus.udp_rx_overflow    = rx_ovf;
    assign bus.udp_rx_drop_cnt    = drop_cnt;
endmodule

// File: tb/tb_udp_rx_packer.sv
// tb/tb_udp_rx_packer.sv - bench for udp_rx_packer: 1024-byte and 16-byte instances on one stimulus stream
module tb_udp_rx_packer;
    localparam int BIG   = 1024;
    localparam int SMALL = 16;
    localparam int BW    = BIG * 8;
`ifdef UDP_RX_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic        rgmii_clk = 1'b0;
    logic        rst;
    logic        rv;
    logic [7:0]  rb;
    logic [15:0] rl;
    logic        rr;
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 rgmii_clk = ~rgmii_clk;

    udp_rx_packer_if #(.MAX_BYTES(BIG),   .CNT_W(16)) if_big ();
    udp_rx_packer_if #(.MAX_BYTES(SMALL), .CNT_W(16)) if_small ();

    assign if_big.udp_rec_data_valid    = rv;
    assign if_big.udp_rec_rdata         = rb;
    assign if_big.udp_rec_data_length   = rl;
    assign if_big.udp_rx_data_ready     = rr;
    assign if_small.udp_rec_data_valid  = rv;
    assign if_small.udp_rec_rdata       = rb;
    assign if_small.udp_rec_data_length = rl;
    assign if_small.udp_rx_data_ready   = rr;

    udp_rx_packer #(.MAX_BYTES(BIG), .CNT_W(16)) dut_big (
        .rgmii_clk(rgmii_clk), .rst(rst), .bus(if_big.slave));
    udp_rx_packer #(.MAX_BYTES(SMALL), .CNT_W(16)) dut_small (
        .rgmii_clk(rgmii_clk), .rst(rst), .bus(if_small.slave));

    typedef struct {
        int          len;
        logic [31:0] head;
        logic [7:0]  base;
        logic [15:0] field;
        int          delay;
        int          len_b;
        bit          ovf_b;
        int          len_s;
        bit          ovf_s;
        bit          err;
        logic [31:0] lo_b;
        logic [31:0] lo_s;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic string tag(input int d);
        return (d == 0) ? "big" : "small";
    endfunction

    function automatic logic [63:0] o_valid(input int d);
        return (d == 0) ? 64'(if_big.udp_rx_data_valid) : 64'(if_small.udp_rx_data_valid);
    endfunction
    function automatic logic [63:0] o_len(input int d);
        return (d == 0) ? 64'(if_big.udp_rx_data_length) : 64'(if_small.udp_rx_data_length);
    endfunction
    function automatic logic [63:0] o_ovf(input int d);
        return (d == 0) ? 64'(if_big.udp_rx_overflow) : 64'(if_small.udp_rx_overflow);
    endfunction
    function automatic logic [63:0] o_err(input int d);
        return (d == 0) ? 64'(if_big.udp_rx_len_err) : 64'(if_small.udp_rx_len_err);
    endfunction
    function automatic logic [63:0] o_drop(input int d);
        return (d == 0) ? 64'(if_big.udp_rx_drop_cnt) : 64'(if_small.udp_rx_drop_cnt);
    endfunction
    function automatic logic [63:0] o_lo(input int d);
        return (d == 0) ? 64'(if_big.udp_rx_data[31:0]) : 64'(if_small.udp_rx_data[31:0]);
    endfunction
    function automatic logic [BW-1:0] o_data(input int d);
        return (d == 0) ? if_big.udp_rx_data : BW'(if_small.udp_rx_data);
    endfunction
    function automatic logic [63:0] upper_zero(input int d, input int len);
        logic [BW-1:0] v;
        v = o_data(d);
        return 64'((v >> (len * 8)) == '0);
    endfunction

    task automatic drive(input logic v, input logic [7:0] b, input logic [15:0] f, input logic r);
        @(posedge rgmii_clk);
        #1;
        rv = v; rb = b; rl = f; rr = r;
        @(negedge rgmii_clk);
    endtask

    function automatic logic [7:0] vbyte(input vec_t v, input int i);
        logic [31:0] h;
        h = v.head;
        if (i < 4) return h[31-8*i -: 8];
        return v.base + 8'(i);
    endfunction

    // random-section model: packet list, per-cycle input trace, expected held packet per cycle
    localparam int NP   = 40;
    localparam int NCYC = 1400;
    int          ps[NP], pe[NP], plen[NP];
    logic [15:0] pfld[NP];
    logic [7:0]  pb[NP][24];
    bit          av[NCYC];
    logic [7:0]  ab[NCYC];
    logic [15:0] af[NCYC];
    bit          ar[NCYC];
    int          hold_idx[NCYC];

    function automatic logic [BW-1:0] exp_data(input int p, input int maxb);
        logic [BW-1:0] r;
        int k;
        r = '0;
        k = (plen[p] < maxb) ? plen[p] : maxb;
        for (int i = 0; i < k; i++) r[(k-1-i)*8 +: 8] = pb[p][i];
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   run_end, c, prev_cons, drops, cons;

        vecs[0] = '{4,   32'hDEADBEEF, 8'h00, 16'd12,  0,  4,   1'b0, 4,  1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{159, 32'h00010203, 8'h00, 16'd167, 20, 159, 1'b0, 16, 1'b1, 1'b0, 32'h9B9C9D9E, 32'h0C0D0E0F};
        vecs[2] = '{20,  32'h01020304, 8'h01, 16'd28,  3,  20,  1'b0, 16, 1'b1, 1'b0, 32'h11121314, 32'h0D0E0F10};
        vecs[3] = '{2,   32'hA55A0000, 8'h00, 16'd10,  0,  2,   1'b0, 2,  1'b0, 1'b0, 32'h0000A55A, 32'h0000A55A};
        vecs[4] = '{6,   32'h11223344, 8'h10, 16'd20,  1,  6,   1'b0, 6,  1'b0, 1'b1, 32'h33441415, 32'h33441415};
        vecs[5] = '{6,   32'h11223344, 8'h10, 16'd14,  0,  6,   1'b0, 6,  1'b0, 1'b0, 32'h33441415, 32'h33441415};
        vecs[6] = '{2,   32'hBEEF0000, 8'h00, 16'd5,   0,  2,   1'b0, 2,  1'b0, 1'b1, 32'h0000BEEF, 32'h0000BEEF};
        vecs[7] = '{16,  32'h00010203, 8'h00, 16'd24,  2,  16,  1'b0, 16, 1'b0, 1'b0, 32'h0C0D0E0F, 32'h0C0D0E0F};
        vecs[8] = '{17,  32'h00010203, 8'h00, 16'd25,  0,  17,  1'b0, 16, 1'b1, 1'b0, 32'h0D0E0F10, 32'h0C0D0E0F};

        rst = 1'b1; rv = 1'b0; rb = 8'h00; rl = 16'h0; rr = 1'b0;
        repeat (3) drive(1'b0, 8'h00, 16'h0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 16'h0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk({tag(d), "_rst_valid"}, o_valid(d), 64'd0);
            chk({tag(d), "_rst_data"},  upper_zero(d, 0), 64'd1);
            chk({tag(d), "_rst_len"},   o_len(d), 64'd0);
            chk({tag(d), "_rst_ovf"},   o_ovf(d), 64'd0);
            chk({tag(d), "_rst_err"},   o_err(d), 64'd0);
            chk({tag(d), "_rst_drop"},  o_drop(d), 64'd0);
        end

        // directed packets: latency, hold with ready low, truncation, length check
        foreach (vecs[n]) begin
            for (int i = 0; i < vecs[n].len; i++) drive(1'b1, vbyte(vecs[n], i), vecs[n].field, 1'b0);
            drive(1'b0, 8'h00, vecs[n].field, 1'b0);
            for (int d = 0; d < 2; d++) chk($sformatf("%s_v%0d_lat1", tag(d), n), o_valid(d), 64'd0);
            for (int k = 0; k <= vecs[n].delay; k++) begin
                drive(1'b0, 8'h00, vecs[n].field, k == vecs[n].delay);
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("%s_v%0d_valid", tag(d), n), o_valid(d), 64'd1);
                    chk($sformatf("%s_v%0d_len", tag(d), n), o_len(d),
                        64'((d == 0) ? vecs[n].len_b : vecs[n].len_s));
                    chk($sformatf("%s_v%0d_ovf", tag(d), n), o_ovf(d),
                        64'((d == 0) ? vecs[n].ovf_b : vecs[n].ovf_s));
                    chk($sformatf("%s_v%0d_err", tag(d), n), o_err(d), 64'(LEN_CHK & vecs[n].err));
                    chk($sformatf("%s_v%0d_lo", tag(d), n), o_lo(d),
                        64'((d == 0) ? vecs[n].lo_b : vecs[n].lo_s));
                    chk($sformatf("%s_v%0d_upper0", tag(d), n),
                        upper_zero(d, (d == 0) ? vecs[n].len_b : vecs[n].len_s), 64'd1);
                end
            end
            drive(1'b0, 8'h00, 16'h0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s_v%0d_clr_valid", tag(d), n), o_valid(d), 64'd0);
                chk($sformatf("%s_v%0d_clr_ovf", tag(d), n), o_ovf(d), 64'd0);
                chk($sformatf("%s_v%0d_clr_err", tag(d), n), o_err(d), 64'd0);
                chk($sformatf("%s_v%0d_keep_len", tag(d), n), o_len(d),
                    64'((d == 0) ? vecs[n].len_b : vecs[n].len_s));
            end
        end

        // packet B arrives while A is held; ready rises mid-B
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(i + 1), 16'd11, 1'b0);
        drive(1'b0, 8'h00, 16'd11, 1'b0);
        drive(1'b0, 8'h00, 16'd11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hB0 + 8'(i), 16'd13, i == 2);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s_drop_b%0d_valid", tag(d), i), o_valid(d), (i <= 2) ? 64'd1 : 64'd0);
                if (i <= 2) begin
                    chk($sformatf("%s_drop_a_lo", tag(d)), o_lo(d), 64'h00010203);
                    chk($sformatf("%s_drop_a_len", tag(d)), o_len(d), 64'd3);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 16'h0, 1'b1);
            for (int d = 0; d < 2; d++) chk($sformatf("%s_drop_tail_valid", tag(d)), o_valid(d), 64'd0);
        end
        for (int d = 0; d < 2; d++) chk({tag(d), "_drop_cnt1"}, o_drop(d), 64'd1);

        // reset in the middle of a 10-byte packet
        drive(1'b1, 8'h30, 16'd18, 1'b0);
        drive(1'b1, 8'h31, 16'd18, 1'b0);
        drive(1'b1, 8'h32, 16'd18, 1'b0);
        rst = 1'b1;
        drive(1'b1, 8'h33, 16'd18, 1'b0);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk({tag(d), "_mrst_valid"}, o_valid(d), 64'd0);
            chk({tag(d), "_mrst_data"},  upper_zero(d, 0), 64'd1);
            chk({tag(d), "_mrst_len"},   o_len(d), 64'd0);
            chk({tag(d), "_mrst_drop"},  o_drop(d), 64'd0);
        end
        for (int i = 4; i < 13; i++) begin
            drive(i < 10, (i < 10) ? 8'h30 + 8'(i) : 8'h00, 16'd18, 1'b1);
            for (int d = 0; d < 2; d++) chk({tag(d), "_mrst_tail_valid"}, o_valid(d), 64'd0);
        end
        drive(1'b1, 8'hA5, 16'd10, 1'b1);
        drive(1'b1, 8'h5A, 16'd10, 1'b1);
        drive(1'b0, 8'h00, 16'd10, 1'b1);
        drive(1'b0, 8'h00, 16'd10, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk({tag(d), "_post_valid"}, o_valid(d), 64'd1);
            chk({tag(d), "_post_lo"},    o_lo(d), 64'h0000A55A);
            chk({tag(d), "_post_len"},   o_len(d), 64'd2);
        end
        drive(1'b0, 8'h00, 16'h0, 1'b0);
        for (int d = 0; d < 2; d++) chk({tag(d), "_post_clr"}, o_valid(d), 64'd0);

        // randomized traffic: random lengths, gaps, field values and ready pattern
        for (int i = 0; i < NCYC; i++) begin
            av[i] = 1'b0; ab[i] = 8'h00; af[i] = 16'h0;
            ar[i] = 1'($urandom_range(0, 1)); hold_idx[i] = -1;
        end
        c = 2;
        for (int p = 0; p < NP; p++) begin
            plen[p] = $urandom_range(1, 24);
            pfld[p] = ($urandom_range(0, 1) == 1) ? 16'(plen[p] + 8) : 16'($urandom_range(0, 40));
            ps[p]   = c;
            for (int i = 0; i < plen[p]; i++) begin
                pb[p][i] = 8'($urandom_range(0, 255));
                av[c + i] = 1'b1; ab[c + i] = pb[p][i]; af[c + i] = pfld[p];
            end
            pe[p] = c + plen[p] - 1;
            c = pe[p] + 1 + $urandom_range(1, 6);
        end
        run_end = c + 12;
        for (int i = c; i < NCYC; i++) ar[i] = 1'b1;

        // a packet is taken only if the previous taken one was handed off strictly before its start;
        // a taken packet is shown from two cycles after its last byte until the first ready cycle
        prev_cons = -1;
        drops = 0;
        for (int p = 0; p < NP; p++) begin
            if (ps[p] <= prev_cons) begin
                drops++;
            end else begin
                cons = pe[p] + 2;
                while (!ar[cons]) cons++;
                for (int k = pe[p] + 2; k <= cons; k++) hold_idx[k] = p;
                prev_cons = cons;
            end
        end

        for (int i = 0; i < run_end; i++) begin
            drive(av[i], ab[i], af[i], ar[i]);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s_rnd_valid_c%0d", tag(d), i), o_valid(d), 64'(hold_idx[i] >= 0));
                if (hold_idx[i] >= 0) begin
                    int p, maxb, kl;
                    p    = hold_idx[i];
                    maxb = (d == 0) ? BIG : SMALL;
                    kl   = (plen[p] < maxb) ? plen[p] : maxb;
                    n_total++;
                    if (o_data(d) === exp_data(p, maxb)) n_pass++;
                    else $display("FAIL %s_rnd_data_p%0d: got %h expected %h", tag(d), p,
                                  o_data(d)[127:0], exp_data(p, maxb)[127:0]);
                    chk($sformatf("%s_rnd_len_p%0d", tag(d), p), o_len(d), 64'(kl));
                    chk($sformatf("%s_rnd_ovf_p%0d", tag(d), p), o_ovf(d), 64'(plen[p] > maxb));
                    chk($sformatf("%s_rnd_err_p%0d", tag(d), p), o_err(d),
                        64'(LEN_CHK && ((pfld[p] < 16'd8) || (plen[p] != int'(pfld[p]) - 8))));
                end
            end
        end
        for (int d = 0; d < 2; d++) chk({tag(d), "_rnd_drop_cnt"}, o_drop(d), 64'(drops));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
